// File: rtl/hazard_bubble_controller.sv
// rtl/hazard_bubble_controller.sv - ID-stage bubble/flush/hold sequencer for the 5-stage pipeline
// Mealy outputs from state and hazard inputs; FSM tracks post-branch flush and memory-wait hold.
module hazard_bubble_controller #(
   parameter int REG_ADDR_W   = 5,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic [REG_ADDR_W-1:0] IDRs,
   input  logic [REG_ADDR_W-1:0] IDRt,
   input  logic                  IDUsesRt,
   input  logic                  EXMemRead,
   input  logic [REG_ADDR_W-1:0] EXRt,
   input  logic                  EXBranchTaken,
   input  logic                  MemWait,
   output logic [1:0]            CtrlMuxSel,
   output logic                  PCWrite,
   output logic                  IFIDWrite,
   output logic                  IFIDFlush,
   output logic                  PipeHold,
   output logic [CNT_W-1:0]      StallCount,
   output logic [CNT_W-1:0]      FlushCount,
   output logic [1:0]            State
);

   typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, HOLD = 2'd2} state_t;

   localparam logic [3:0]       FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t     state_q, state_d;
   logic [3:0] flush_cnt_q, flush_cnt_d;
   logic       stall_inc, flush_inc, load_use;

   assign load_use = EXMemRead && (EXRt != '0) &&
                     ((EXRt == IDRs) || (IDUsesRt && (EXRt == IDRt)));
   assign State = state_q;

   always_comb begin
      CtrlMuxSel  = 2'd0;
      PCWrite     = 1'b1;
      IFIDWrite   = 1'b1;
      IFIDFlush   = 1'b0;
      PipeHold    = 1'b0;
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      case (state_q)
         RUN: begin
            if (MemWait) begin
               PipeHold  = 1'b1;
               PCWrite   = 1'b0;
               IFIDWrite = 1'b0;
               stall_inc = 1'b1;
               state_d   = HOLD;
            end else if (EXBranchTaken) begin
               // branch wins over load-use: the stalled instruction is being flushed anyway
               IFIDFlush  = 1'b1;
               CtrlMuxSel = 2'd1;
               flush_inc  = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  flush_cnt_d = FLUSH_LOAD;
                  state_d     = FLUSH;
               end
            end else if (load_use) begin
               CtrlMuxSel = 2'd1;
               PCWrite    = 1'b0;
               IFIDWrite  = 1'b0;
               stall_inc  = 1'b1;
            end
         end
         FLUSH: begin
            if (MemWait) begin
               PipeHold  = 1'b1;
               PCWrite   = 1'b0;
               IFIDWrite = 1'b0;
               stall_inc = 1'b1;
            end else begin
               IFIDFlush   = 1'b1;
               CtrlMuxSel  = 2'd1;
               flush_cnt_d = flush_cnt_q - 4'd1;
               if (flush_cnt_q == 4'd1) state_d = RUN;
            end
         end
         HOLD: begin
            if (MemWait) begin
               PipeHold  = 1'b1;
               PCWrite   = 1'b0;
               IFIDWrite = 1'b0;
               stall_inc = 1'b1;
            end else begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
      if (!Rst) begin
         CtrlMuxSel = 2'd1;
         PCWrite    = 1'b0;
         IFIDWrite  = 1'b0;
         IFIDFlush  = 1'b0;
         PipeHold   = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q     <= RUN;
         flush_cnt_q <= 4'd0;
         StallCount  <= '0;
         FlushCount  <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         if (stall_inc && (StallCount != '1)) StallCount <= StallCount + CNT_ONE;
         if (flush_inc && (FlushCount != '1)) FlushCount <= FlushCount + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_hazard_bubble_controller.sv
// tb/tb_hazard_bubble_controller.sv - directed bench with per-cycle reference model
// Two instances share stimulus: default counters and a 4-bit counter build for saturation.
module tb_hazard_bubble_controller;

   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic [4:0] IDRs = '0, IDRt = '0, EXRt = '0;
   logic       IDUsesRt = 1'b0, EXMemRead = 1'b0, EXBranchTaken = 1'b0, MemWait = 1'b0;

   logic [1:0]  sel_a, st_a, sel_b, st_b;
   logic        pcw_a, ifw_a, iff_a, ph_a, pcw_b, ifw_b, iff_b, ph_b;
   logic [15:0] sc_a, fc_a;
   logic [3:0]  sc_b, fc_b;

   int n_checks = 0;
   int n_fail   = 0;

   hazard_bubble_controller #(.REG_ADDR_W(5), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
      .Clk(Clk), .Rst(Rst), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
      .EXMemRead(EXMemRead), .EXRt(EXRt), .EXBranchTaken(EXBranchTaken), .MemWait(MemWait),
      .CtrlMuxSel(sel_a), .PCWrite(pcw_a), .IFIDWrite(ifw_a), .IFIDFlush(iff_a),
      .PipeHold(ph_a), .StallCount(sc_a), .FlushCount(fc_a), .State(st_a));

   hazard_bubble_controller #(.REG_ADDR_W(5), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
      .Clk(Clk), .Rst(Rst), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
      .EXMemRead(EXMemRead), .EXRt(EXRt), .EXBranchTaken(EXBranchTaken), .MemWait(MemWait),
      .CtrlMuxSel(sel_b), .PCWrite(pcw_b), .IFIDWrite(ifw_b), .IFIDFlush(iff_b),
      .PipeHold(ph_b), .StallCount(sc_b), .FlushCount(fc_b), .State(st_b));

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: remaining flush cycles, hold flag, unbounded event totals
   int m_flush_left = 0;
   bit m_holding    = 0;
   int m_stalls     = 0;
   int m_flushes    = 0;

   function automatic bit lu_hazard();
      return EXMemRead && EXRt != 0 && (EXRt == IDRs || (IDUsesRt && EXRt == IDRt));
   endfunction

   always @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         m_flush_left = 0; m_holding = 0; m_stalls = 0; m_flushes = 0;
      end else if (m_holding) begin
         if (MemWait) m_stalls++; else m_holding = 0;
      end else if (m_flush_left > 0) begin
         if (MemWait) m_stalls++; else m_flush_left--;
      end else if (MemWait) begin
         m_holding = 1; m_stalls++;
      end else if (EXBranchTaken) begin
         m_flushes++; m_flush_left = 2 - 1;
      end else if (lu_hazard()) begin
         m_stalls++;
      end
   end

   always @(negedge Clk) begin
      int e_sel, e_pcw, e_ifw, e_iff, e_ph, e_st;
      e_sel = 0; e_pcw = 1; e_ifw = 1; e_iff = 0; e_ph = 0;
      e_st = m_holding ? 2 : (m_flush_left > 0 ? 1 : 0);
      if (!Rst) begin
         e_sel = 1; e_pcw = 0; e_ifw = 0; e_st = 0;
      end else if (MemWait && (m_holding || m_flush_left > 0 || e_st == 0)) begin
         e_ph = 1; e_pcw = 0; e_ifw = 0;
      end else if (m_holding) begin
         e_sel = 0;
      end else if (m_flush_left > 0 || EXBranchTaken) begin
         e_iff = 1; e_sel = 1;
      end else if (lu_hazard()) begin
         e_sel = 1; e_pcw = 0; e_ifw = 0;
      end
      chk("sel_a", sel_a, e_sel);   chk("sel_b", sel_b, e_sel);
      chk("pcw_a", pcw_a, e_pcw);   chk("pcw_b", pcw_b, e_pcw);
      chk("ifw_a", ifw_a, e_ifw);   chk("ifw_b", ifw_b, e_ifw);
      chk("iff_a", iff_a, e_iff);   chk("iff_b", iff_b, e_iff);
      chk("hold_a", ph_a, e_ph);    chk("hold_b", ph_b, e_ph);
      chk("state_a", st_a, e_st);   chk("state_b", st_b, e_st);
      chk("stall_a", sc_a, m_stalls > 65535 ? 65535 : m_stalls);
      chk("stall_b", sc_b, m_stalls > 15 ? 15 : m_stalls);
      chk("flush_a", fc_a, m_flushes > 65535 ? 65535 : m_flushes);
      chk("flush_b", fc_b, m_flushes > 15 ? 15 : m_flushes);
   end

   task automatic step(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic clear_in();
      IDRs = 0; IDRt = 0; EXRt = 0; IDUsesRt = 0;
      EXMemRead = 0; EXBranchTaken = 0; MemWait = 0;
   endtask

   initial begin
      #8;
      chk("rst_sel", sel_a, 1);
      chk("rst_pcw", pcw_a, 0);
      step(2);
      Rst = 1'b1;
      step(2);
      chk("idle_sel", sel_a, 0);
      chk("idle_pcw", pcw_a, 1);
      chk("idle_state", st_a, 0);
      chk("idle_stall", sc_a, 0);

      EXMemRead = 1; EXRt = 8; IDRs = 8; #1;
      chk("lu_sel", sel_a, 1);
      chk("lu_pcw", pcw_a, 0);
      chk("lu_ifw", ifw_a, 0);
      step(1);
      EXMemRead = 0; #1;
      chk("lu_after_sel", sel_a, 0);
      chk("lu_after_stall", sc_a, 1);
      step(1);

      clear_in(); EXMemRead = 1; #1;
      chk("r0_nostall", sel_a, 0);
      EXRt = 9; IDRt = 9; IDRs = 1; #1;
      chk("rt_unused", sel_a, 0);
      IDUsesRt = 1; #1;
      chk("rt_used", sel_a, 1);
      step(1);
      clear_in();
      step(1);

      EXMemRead = 1; EXRt = 8; IDRs = 8; EXBranchTaken = 1; #1;
      chk("br_iff0", iff_a, 1);
      chk("br_pcw0", pcw_a, 1);
      step(1);
      clear_in(); #1;
      chk("br_iff1", iff_a, 1);
      chk("br_state1", st_a, 1);
      step(1);
      chk("br_iff2", iff_a, 0);
      chk("br_state2", st_a, 0);
      chk("br_fc", fc_a, 1);
      chk("br_sc", sc_a, 2);

      EXBranchTaken = 1;
      step(1);
      EXBranchTaken = 0; MemWait = 1; #1;
      chk("fh_hold", ph_a, 1);
      chk("fh_pcw", pcw_a, 0);
      chk("fh_state", st_a, 1);
      step(3);
      MemWait = 0; #1;
      chk("fh_resume", iff_a, 1);
      chk("fh_sc", sc_a, 5);
      step(1);
      chk("fh_done", st_a, 0);
      chk("fh_fc", fc_a, 2);

      MemWait = 1;
      step(20);
      chk("sat_b", sc_b, 15);
      chk("sat_a", sc_a, 25);
      chk("sat_state", st_a, 2);
      #2 Rst = 1'b0; #1;
      chk("arst_state", st_a, 0);
      chk("arst_sc", sc_a, 0);
      chk("arst_fc", fc_a, 0);
      chk("arst_sel", sel_a, 1);
      step(1);
      clear_in(); Rst = 1'b1;
      step(1);

      MemWait = 1; EXBranchTaken = 1;
      step(1);
      MemWait = 0; #1;
      chk("hold_exit_iff", iff_a, 0);
      chk("hold_exit_state", st_a, 2);
      step(1);
      chk("reeval_iff", iff_a, 1);
      step(1);
      clear_in();
      step(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
